// File: rtl/mc_pkg.sv
// Shared encodings, FSM state type and decoded control bundle for the multi-cycle MIPS-subset machine.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_RDCE    = 6'h2c;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        use_imm;
    logic        dst_rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        rdce;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR -> control bundle.
// MC_MACHINE_RDCE_EN enables decoding of funct 0x2c as rdce; otherwise it is illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ir_i,
  output ctrl_t       ctrl_o
);

  // shamt is not part of this ISA subset
  logic unused_shamt;
  assign unused_shamt = ^ir_i[10:6];

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    ctrl_o.rs     = ir_i[25:21];
    ctrl_o.rt     = ir_i[20:16];
    ctrl_o.rd     = ir_i[15:11];
    ctrl_o.imm    = sext16(ir_i[15:0]);
    case (ir_i[31:26])
      OP_RTYPE: begin
        ctrl_o.dst_rd    = 1'b1;
        ctrl_o.reg_write = 1'b1;
        case (ir_i[5:0])
          FN_ADD: ctrl_o.alu_op = ALU_ADD;
          FN_SUB: ctrl_o.alu_op = ALU_SUB;
          FN_AND: ctrl_o.alu_op = ALU_AND;
          FN_OR:  ctrl_o.alu_op = ALU_OR;
          FN_SLT: ctrl_o.alu_op = ALU_SLT;
`ifdef MC_MACHINE_RDCE_EN
          FN_RDCE: ctrl_o.rdce = 1'b1;
`endif
          // syscall lands here too: it stops the machine
          default: begin
            ctrl_o.illegal   = 1'b1;
            ctrl_o.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ:  ctrl_o.branch  = 1'b1;
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_machine.sv
// Multi-cycle MIPS-subset machine with external req/ready instruction and data memories.
// MC_MACHINE_RDCE_EN compiles in the rdce instruction and its write-back path.
module mc_machine
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          FLAG_BIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  // Handshake: a req stays high with its address/data stable until the cycle
  // in which ready is seen high; ready while req is low is ignored.
  state_e      state_q;
  logic [31:0] pc_q, npc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0] gpr_q [32];
  logic        imem_req_q, dmem_req_q, dmem_we_q, halted_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;

  ctrl_t       ctrl;
  logic [31:0] alu_b, alu_d, br_target, wb_data;
  logic [4:0]  wb_dst;

  mc_decode u_decode (
    .ir_i   (ir_q),
    .ctrl_o (ctrl)
  );

  assign alu_b     = ctrl.use_imm ? ctrl.imm : b_q;
  assign br_target = npc_q + {ctrl.imm[29:0], 2'b00};

  always_comb begin
    alu_d = a_q + alu_b;
    case (ctrl.alu_op)
      ALU_SUB: alu_d = a_q - alu_b;
      ALU_AND: alu_d = a_q & alu_b;
      ALU_OR:  alu_d = a_q | alu_b;
      ALU_SLT: alu_d = {31'd0, $signed(a_q) < $signed(alu_b)};
      default: alu_d = a_q + alu_b;
    endcase
  end

  always_comb begin
    wb_dst  = ctrl.dst_rd ? ctrl.rd : ctrl.rt;
    wb_data = ctrl.mem_read ? mdr_q : alu_q;
`ifdef MC_MACHINE_RDCE_EN
    // rdce steers the rs value to rd or rt depending on one bit of itself
    if (ctrl.rdce) begin
      wb_dst  = a_q[FLAG_BIT] ? ctrl.rd : ctrl.rt;
      wb_data = a_q;
    end
`endif
  end

`ifndef MC_MACHINE_RDCE_EN
  logic unused_rdce;
  assign unused_rdce = ctrl.rdce ^ a_q[FLAG_BIT];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (imem_ready) begin
            ir_q       <= imem_rdata;
            npc_q      <= pc_q + 32'd4;
            imem_req_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          a_q <= gpr_q[ctrl.rs];
          b_q <= gpr_q[ctrl.rt];
          if (ctrl.illegal) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (ctrl.branch) begin
            pc_q       <= (a_q == b_q) ? br_target : npc_q;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end else if (ctrl.mem_read || ctrl.mem_write) begin
            if (alu_d[1:0] != 2'b00) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ctrl.mem_write;
              dmem_addr_q  <= alu_d;
              dmem_wdata_q <= b_q;
              state_q      <= MEM;
            end
          end else begin
            alu_q   <= alu_d;
            state_q <= WB;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              pc_q       <= npc_q;
              imem_req_q <= 1'b1;
              state_q    <= FETCH;
            end else begin
              mdr_q   <= dmem_rdata;
              state_q <= WB;
            end
          end
        end
        WB: begin
          if (ctrl.reg_write && wb_dst != 5'd0) gpr_q[wb_dst] <= wb_data;
          pc_q       <= npc_q;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  // retire marks the final cycle of an instruction, so a store's depends on dmem_ready
  assign retire = (state_q == WB) ||
                  (state_q == EXEC && ctrl.branch) ||
                  (state_q == MEM && dmem_we_q && dmem_ready);

endmodule

// File: tb/tb_mc_machine.sv
// Directed, table-driven bench for mc_machine; expectations honour MC_MACHINE_RDCE_EN.
module tb_mc_machine;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] SYSCALL = 32'h0000_000c;

  logic        clk, reset;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;

  mc_machine #(.RESET_PC(RST_PC), .FLAG_BIT(0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .retire(retire), .halted(halted)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory models ----------------
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  logic [5:0]  iidx;
  int          dlat = 0;
  int          dwait = 0;

  assign iidx       = 6'((imem_addr - RST_PC) >> 2);
  assign imem_rdata = imem[iidx];
  assign imem_ready = imem_req;
  assign dmem_rdata = dmem[dmem_addr[5:2]];
  assign dmem_ready = dmem_req && (dwait >= dlat);

  always @(posedge clk) begin
    if (!reset || !dmem_req || dmem_ready) dwait <= 0;
    else dwait <= dwait + 1;
  end

  // ---------------- monitor ----------------
  int          ret_cyc_q[$];
  logic [63:0] st_q[$];
  int          burst_q[$];
  logic [31:0] burst_addr_q[$];
  logic        dprev = 1'b0, addr_moved = 1'b0, dmem_seen = 1'b0;
  int          run_len = 0;
  logic [31:0] run_addr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      ret_cyc_q.delete(); st_q.delete(); burst_q.delete(); burst_addr_q.delete();
      dprev <= 1'b0; addr_moved <= 1'b0; dmem_seen <= 1'b0; run_len <= 0;
    end else begin
      if (retire) ret_cyc_q.push_back(cyc);
      if (dmem_req && dmem_ready && dmem_we) st_q.push_back({dmem_addr, dmem_wdata});
      if (dmem_req) begin
        dmem_seen <= 1'b1;
        if (!dprev) begin
          run_len  <= 1;
          run_addr <= dmem_addr;
        end else begin
          run_len <= run_len + 1;
          if (dmem_addr != run_addr) addr_moved <= 1'b1;
        end
      end else if (dprev) begin
        burst_q.push_back(run_len);
        burst_addr_q.push_back(run_addr);
      end
      dprev <= dmem_req;
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_stores(input string name);
    check({name, "_nstores"}, 64'(st_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < st_q.size()) check({name, "_store"}, st_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = SYSCALL;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    exp_q.delete();
  endtask

  task automatic reset_and_start();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_until_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_halt_reached"}, 64'(halted), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    clear_prog();

    vecs[0] = '{"add",       enc_r(1, 2, 3, 6'h20), 32'd7,          32'd8,          32'd15};
    vecs[1] = '{"add_wrap",  enc_r(1, 2, 3, 6'h20), 32'hFFFF_FFFF,  32'd2,          32'd1};
    vecs[2] = '{"sub_neg",   enc_r(1, 2, 3, 6'h22), 32'd5,          32'd7,          32'hFFFF_FFFE};
    vecs[3] = '{"and",       enc_r(1, 2, 3, 6'h24), 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
    vecs[4] = '{"or",        enc_r(1, 2, 3, 6'h25), 32'hF000_0000,  32'h0000_000F,  32'hF000_000F};
    vecs[5] = '{"slt_neg",   enc_r(1, 2, 3, 6'h2a), 32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[6] = '{"slt_pos",   enc_r(1, 2, 3, 6'h2a), 32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[7] = '{"slt_min",   enc_r(1, 2, 3, 6'h2a), 32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
    vecs[8] = '{"addi_neg",  enc_i(6'h08, 1, 3, 16'hFFFD), 32'd2,   32'd0,          32'hFFFF_FFFF};
    vecs[9] = '{"addi_max",  enc_i(6'h08, 1, 3, 16'h7FFF), 32'd1,   32'd0,          32'h0000_8000};

    // reset values while reset is held, then first cycle after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_dmem_we",  64'(dmem_we),  64'd0);
    check("rst_retire",   64'(retire),   64'd0);
    check("rst_halted",   64'(halted),   64'd0);
    check("rst_pc",       64'(pc),       64'(RST_PC));
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_imem_req", 64'(imem_req), 64'd1);
    check("rel_imem_addr", 64'(imem_addr), 64'(RST_PC));
    check("rel_halted",   64'(halted),   64'd0);
    check("rel_retire",   64'(retire),   64'd0);

    // ALU vectors: lw r1,0 ; lw r2,4 ; op r3 ; sw r3,8 ; syscall
    for (int i = 0; i < 10; i++) begin
      clear_prog();
      imem[0] = enc_i(6'h23, 0, 1, 16'd0);
      imem[1] = enc_i(6'h23, 0, 2, 16'd4);
      imem[2] = vecs[i].instr;
      imem[3] = enc_i(6'h2b, 0, 3, 16'd8);
      dmem[0] = vecs[i].a;
      dmem[1] = vecs[i].b;
      dlat    = 0;
      exp_q.push_back({32'd8, vecs[i].exp});
      reset_and_start();
      run_until_halt(vecs[i].name, 100);
      check_stores(vecs[i].name);
      check({vecs[i].name, "_pc"}, 64'(pc), 64'(RST_PC + 32'd16));
    end

    // addi r1,r0,5 ; add r2,r1,r1 ; sw r2,0
    clear_prog();
    imem[0] = enc_i(6'h08, 0, 1, 16'd5);
    imem[1] = enc_r(1, 1, 2, 6'h20);
    imem[2] = enc_i(6'h2b, 0, 2, 16'd0);
    exp_q.push_back({32'd0, 32'd10});
    reset_and_start();
    run_until_halt("addi_add", 100);
    check_stores("addi_add");
    check("addi_add_nret", 64'(ret_cyc_q.size()), 64'd3);
    if (ret_cyc_q.size() >= 2) check("addi_add_gap", 64'(ret_cyc_q[1] - ret_cyc_q[0]), 64'd4);

    // addi r0,r0,0 ; lw r3,4 (3 wait cycles) ; sw r3,8
    clear_prog();
    imem[0] = enc_i(6'h08, 0, 0, 16'd0);
    imem[1] = enc_i(6'h23, 0, 3, 16'd4);
    imem[2] = enc_i(6'h2b, 0, 3, 16'd8);
    dmem[1] = 32'hDEAD_BEEF;
    dlat    = 3;
    exp_q.push_back({32'd8, 32'hDEAD_BEEF});
    reset_and_start();
    run_until_halt("lw_wait", 200);
    check_stores("lw_wait");
    check("lw_nret", 64'(ret_cyc_q.size()), 64'd3);
    if (ret_cyc_q.size() >= 3) begin
      check("lw_cycles", 64'(ret_cyc_q[1] - ret_cyc_q[0]), 64'd8);
      check("sw_cycles", 64'(ret_cyc_q[2] - ret_cyc_q[1]), 64'd7);
    end
    check("lw_nbursts", 64'(burst_q.size()), 64'd2);
    if (burst_q.size() >= 1) begin
      check("lw_req_len",  64'(burst_q[0]), 64'd4);
      check("lw_req_addr", 64'(burst_addr_q[0]), 64'd4);
    end
    check("lw_addr_stable", 64'(addr_moved), 64'd0);
    dlat = 0;

    // beq r0,r0,-1 loops on itself
    clear_prog();
    imem[0] = enc_i(6'h04, 0, 0, 16'hFFFF);
    reset_and_start();
    repeat (12) @(posedge clk);
    #1;
    check("beq_self_pc", 64'(pc), 64'(RST_PC));
    check("beq_self_halted", 64'(halted), 64'd0);
    check("beq_self_nret", 64'(ret_cyc_q.size()), 64'd3);
    if (ret_cyc_q.size() >= 2) check("beq_self_gap", 64'(ret_cyc_q[1] - ret_cyc_q[0]), 64'd3);

    // addi r1,r0,1 ; beq r1,r0,-1 (not taken) ; syscall
    clear_prog();
    imem[0] = enc_i(6'h08, 0, 1, 16'd1);
    imem[1] = enc_i(6'h04, 1, 0, 16'hFFFF);
    reset_and_start();
    run_until_halt("beq_nt", 100);
    check("beq_nt_pc", 64'(pc), 64'(RST_PC + 32'd8));
    check("beq_nt_nret", 64'(ret_cyc_q.size()), 64'd2);
    if (ret_cyc_q.size() >= 2) check("beq_nt_gap", 64'(ret_cyc_q[1] - ret_cyc_q[0]), 64'd3);

    // beq r0,r0,+1 skips one instruction
    clear_prog();
    imem[0] = enc_i(6'h04, 0, 0, 16'd1);
    imem[1] = enc_i(6'h08, 0, 1, 16'd7);
    imem[2] = enc_i(6'h08, 1, 2, 16'd9);
    imem[3] = enc_i(6'h2b, 0, 2, 16'd0);
    exp_q.push_back({32'd0, 32'd9});
    reset_and_start();
    run_until_halt("beq_fwd", 100);
    check_stores("beq_fwd");

    // rdce r3(rd), r2(rt), rs=r1
    for (int k = 0; k < 2; k++) begin
      clear_prog();
      imem[0] = enc_i(6'h23, 0, 1, 16'd0);
      imem[1] = enc_i(6'h23, 0, 2, 16'd4);
      imem[2] = enc_r(1, 2, 3, 6'h2c);
      imem[3] = enc_i(6'h2b, 0, 2, 16'd12);
      imem[4] = enc_i(6'h2b, 0, 3, 16'd16);
      dmem[0] = (k == 0) ? 32'h1 : 32'h2;
      dmem[1] = 32'h55;
`ifdef MC_MACHINE_RDCE_EN
      if (k == 0) begin
        exp_q.push_back({32'd12, 32'h55});
        exp_q.push_back({32'd16, 32'h1});
      end else begin
        exp_q.push_back({32'd12, 32'h2});
        exp_q.push_back({32'd16, 32'h0});
      end
      reset_and_start();
      run_until_halt("rdce", 150);
      check_stores("rdce");
      check("rdce_nret", 64'(ret_cyc_q.size()), 64'd5);
`else
      reset_and_start();
      run_until_halt("rdce_off", 150);
      check_stores("rdce_off");
      check("rdce_off_nret", 64'(ret_cyc_q.size()), 64'd2);
      check("rdce_off_pc", 64'(pc), 64'(RST_PC + 32'd8));
`endif
    end

    // illegal opcode halts at its own pc with no retire
    clear_prog();
    imem[0] = 32'hFC00_0000;
    reset_and_start();
    run_until_halt("illegal", 50);
    check("illegal_pc", 64'(pc), 64'(RST_PC));
    check("illegal_nret", 64'(ret_cyc_q.size()), 64'd0);

    // addi r1,r0,6 ; sw r1,0(r1) -> misaligned
    clear_prog();
    imem[0] = enc_i(6'h08, 0, 1, 16'd6);
    imem[1] = enc_i(6'h2b, 1, 1, 16'd0);
    reset_and_start();
    run_until_halt("misalign", 100);
    check("misalign_pc", 64'(pc), 64'(RST_PC + 32'd4));
    check("misalign_no_dreq", 64'(dmem_seen), 64'd0);
    check("misalign_nret", 64'(ret_cyc_q.size()), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("misalign_sticky", 64'(halted), 64'd1);

    // reset in the middle of a slow load
    clear_prog();
    imem[0] = enc_i(6'h23, 0, 1, 16'd0);
    imem[1] = enc_i(6'h2b, 0, 1, 16'd4);
    dmem[0] = 32'h1234_5678;
    dlat    = 20;
    reset_and_start();
    begin
      int n = 0;
      while (!dmem_req && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("midmem_req_seen", 64'(dmem_req), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midmem_dreq_drop", 64'(dmem_req), 64'd0);
    check("midmem_pc", 64'(pc), 64'(RST_PC));
    check("midmem_imem_req", 64'(imem_req), 64'd0);
    dlat = 0;
    exp_q.push_back({32'd4, 32'h1234_5678});
    reset_and_start();
    run_until_halt("after_midmem", 100);
    check_stores("after_midmem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_machine.md
Name: mc_machine

Overview:
- Multi-cycle successor to the single-cycle MIPS-subset machine.
- Same ISA subset, including the custom rdce instruction, with generalised rdce flag selection and a configurable reset PC.
- Instruction and data memories sit outside the block behind req/ready handshakes, so variable-latency memory is tolerated.
- Halts cleanly on syscall, illegal opcode or misaligned access.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset; bits[1:0] must be 0.
- FLAG_BIT, 0, bit of rs value that selects the rdce destination (0..31).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_rdata  in  32  instruction word, valid when imem_ready
- imem_ready  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word-aligned data address
- dmem_wdata  out  32  store data (rt)
- dmem_rdata  in  32  load data, valid when dmem_ready
- dmem_ready  in  1  data access complete
- pc  out  32  current PC
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sticky; set in HALT

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=FETCH, pc=RESET_PC, all 32 GPRs=0.
  - imem_req=0, dmem_req=0, dmem_we=0, retire=0, halted=0.
  - Reset mid-transaction drops any req the following cycle and discards the pending access.
- GPRs: 32x32; r0 reads 0 and writes to r0 are dropped. The register file is internal.
- State FETCH: imem_req=1 held until imem_ready. On ready: IR<=imem_rdata, npc<=pc+4, go to DECODE. imem_ready while req=0 is ignored.
- State DECODE:
  - A<=GPR[rs], B<=GPR[rt], imm=sign-extended IR[15:0].
  - Decode opcodes: R-type 0x00 (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a, rdce 0x2c, syscall 0x0c), addi 0x08, lw 0x23, sw 0x2b, beq 0x04.
  - syscall or any other encoding -> HALT.
- State EXEC:
  - ALU computes; add/sub wrap modulo 2^32 with no overflow trap; slt is signed.
  - beq: pc <= (A==B) ? npc+(imm<<2) : npc (mod 2^32), retire=1, go to FETCH.
  - lw/sw: if addr[1:0]!=0 -> HALT, else MEM.
  - Others -> WB.
- State MEM:
  - dmem_req=1 and dmem_we=(sw) are held stable with addr/wdata until dmem_ready.
  - sw: on ready, pc<=npc, retire=1, go to FETCH.
  - lw: on ready, MDR<=dmem_rdata, go to WB.
- State WB:
  - Destination register: rd for R-type, rt for addi/lw.
  - rdce: destination = A[FLAG_BIT] ? rd : rt; data = A (rs value).
  - Write the register, pc<=npc, retire=1, go to FETCH.
- State HALT: halted=1, no requests, pc frozen at the offending instruction. Only reset leaves HALT.
- Latency with zero-wait memory (ready in the cycle after req rises counts as 1 wait cycle):
  - beq 3 cycles, R/addi/sw 4, lw 5, each plus memory wait cycles.
- retire is asserted in the last cycle of each instruction and never for a halting one.

Optional Feature:
- Macro: MC_MACHINE_RDCE_EN.
- Defined: funct 0x2c decodes as rdce, behaving as above.
- Undefined: funct 0x2c is illegal -> HALT. The rdce datapath (destination mux, A write-back path) is compiled out.

Decomposition:
- Package mc_pkg holds:
  - opcode/funct localparams
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - 3-bit ALU op codes
- Sub-module mc_decode: combinational IR -> control bundle (ALU op, reg dest select, mem/branch/rdce/illegal flags).
- FSM, datapath registers and the GPR array stay in mc_machine.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> pc=32'h0040_0000, imem_req=1 on the first cycle, halted=0, retire=0.
- addi r1,r0,5 then add r2,r1,r1 with zero-wait memory -> r2=10, retire pulses exactly 4 cycles apart.
- lw r3,4(r0) with dmem_ready delayed 3 cycles and dmem_rdata=32'hDEAD_BEEF -> dmem_req held 4 cycles with a stable addr of 4, r3=DEADBEEF, 8 cycles total.
- beq r0,r0,-1 -> pc unchanged after 3 cycles; repeat with unequal operands -> pc+4.
- rdce with rs=32'h1 (FLAG_BIT=0) -> value written to rd; rs=32'h2 -> written to rt. Without the macro, the same encoding sets halted=1 with no retire.
- Misaligned sw address 32'h6 -> halted=1, dmem_req never asserted. Reset asserted mid-MEM -> dmem_req=0 next cycle and pc=RESET_PC.
